pdp8_ifu_fetch_initiator: RTL and testbench
===========================================

Name: pdp8_ifu_fetch_initiator

Overview:
- Instruction-fetch initiator for the PDP-8 fetch/decode path.
- Holds the 12-bit PC and issues single-cycle `ifu_rd_req` pulses with `ifu_rd_addr` to instruction memory (or the bench's stimulus responder).
- Samples `ifu_rd_data` a fixed number of cycles later and presents the instruction plus its PC to decode with a valid/ack handshake.
- Supports PC redirect (JMP/JMS/skip) with flush of an in-flight fetch, plus halt and start control.

Parameters:
- RD_LATENCY, 2: cycles from the `ifu_rd_req` cycle to the cycle where `ifu_rd_data` is valid. Legal range 1..7.
- RESET_PC, 12'o0200: PC value at reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; in IDLE, loads `base_addr` into PC and begins fetching.
- base_addr  in  12  start address.
- halt  in  1  level; stop after the current instruction is accepted.
- ifu_rd_req  out  1  one-cycle read request to memory.
- ifu_rd_addr  out  12  read address; valid only while `ifu_rd_req`=1, else 0.
- ifu_rd_data  in  12  memory read data, valid RD_LATENCY cycles after the request.
- instr  out  12  fetched instruction word.
- instr_pc  out  12  address `instr` was fetched from.
- instr_valid  out  1  `instr`/`instr_pc` valid.
- instr_ack  in  1  decode accepts the instruction (sampled only when `instr_valid`=1).
- pc_load  in  1  redirect PC to `pc_load_addr`.
- pc_load_addr  in  12  redirect target.
- busy  out  1  1 in any state except IDLE.
- fetch_count  out  16  accepted-instruction count (optional feature).

Behaviour:
- Reset (async, active-high):
  - state=IDLE, pc=RESET_PC.
  - `ifu_rd_req`=0, `ifu_rd_addr`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, `busy`=0, flush=0, `fetch_count`=0.
  - Reset mid-fetch abandons the request; late `ifu_rd_data` is ignored.
- FSM states: IDLE, REQ, WAIT, HOLD. All outputs registered.
- IDLE:
  - `start`=1: pc<=`base_addr`, go to REQ.
  - `pc_load`=1 without `start`: pc<=`pc_load_addr`, stay in IDLE.
  - `start` and `pc_load` together: `start` wins.
  - `start` outside IDLE is ignored.
- REQ (one cycle):
  - `ifu_rd_req`=1, `ifu_rd_addr`=pc.
  - Load latency counter to RD_LATENCY-1, go to WAIT.
  - Never two requests outstanding.
- WAIT:
  - Counter decrements each cycle. Data is sampled on the clock edge ending cycle T0+RD_LATENCY, where T0 is the REQ cycle.
  - flush=0: `instr`<=`ifu_rd_data`, `instr_pc`<=pc, `instr_valid`<=1, go to HOLD. `instr_valid` is first high in cycle T0+RD_LATENCY+1.
  - flush=1: discard data, clear flush, go to REQ with the redirected pc.
  - `pc_load` during REQ or WAIT: pc<=`pc_load_addr`, flush<=1.
- HOLD:
  - `instr_valid`=1; `instr` and `instr_pc` stable until ack.
  - On `instr_ack`: `instr_valid`<=0, `fetch_count`++.
  - Next pc on ack: `pc_load`=1 gives `pc_load_addr`, otherwise pc+1 (mod 4096, 12'o7777 -> 12'o0000).
  - Next state on ack: `halt`=1 goes to IDLE, otherwise REQ.
  - `pc_load` in HOLD without ack: pc<=`pc_load_addr`, `instr_valid` stays 1; the next request uses the new pc after ack.
  - `halt` without ack has no effect.
- Throughput: one instruction per RD_LATENCY+2 cycles when ack is immediate.
- `busy`=(state!=IDLE).

Optional Feature:
- Macro: IFU_FETCH_STATS_EN.
- Defined: `fetch_count` is a 16-bit counter of accepted instructions (HOLD with `instr_ack`). Wraps 16'hFFFF->0. Cleared by reset only.
- Not defined: `fetch_count` is tied to 0 and no counter logic is synthesized. The port is always present.

Test Plan:
- Reset, then `start` with `base_addr`=12'o0200, responder returns 12'o7000 at RD_LATENCY=2, ack immediately:
  - `ifu_rd_req` at cycle 1 with addr 12'o0200.
  - `instr_valid` at cycle 4, `instr`=12'o7000, `instr_pc`=12'o0200.
  - Next request addr 12'o0201.
- Hold `instr_ack`=0 for 5 cycles: `instr`/`instr_pc` stable, no new `ifu_rd_req`. After ack, next addr = previous+1.
- PC wrap: `start` at 12'o7777, ack → next `ifu_rd_addr`=12'o0000.
- `pc_load`=1 with `pc_load_addr`=12'o0400 during WAIT:
  - Returned data is dropped; no `instr_valid` for the old address.
  - Next `ifu_rd_req` addr 12'o0400.
- `halt`=1 while in HOLD, then ack → IDLE, `busy`=0, no further requests. `start` with 12'o1000 resumes there.
- Assert `reset` during WAIT, then drive `ifu_rd_data`:
  - All outputs 0, `instr_valid` stays 0.
  - With IFU_FETCH_STATS_EN, 3 acks give `fetch_count`=3, and it returns to 0 on reset.

Source files
------------

// File: rtl/pdp8_ifu_fetch_initiator.sv
// PDP-8 instruction-fetch initiator: issues single-cycle memory reads and hands words to decode.
// Optional accepted-instruction counter on fetch_count is enabled by defining IFU_FETCH_STATS_EN.
module pdp8_ifu_fetch_initiator #(
    parameter int          RD_LATENCY = 2,
    parameter logic [11:0] RESET_PC   = 12'o0200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] base_addr,
    input  logic        halt,
    output logic        ifu_rd_req,
    output logic [11:0] ifu_rd_addr,
    input  logic [11:0] ifu_rd_data,
    output logic [11:0] instr,
    output logic [11:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        pc_load,
    input  logic [11:0] pc_load_addr,
    output logic        busy,
    output logic [15:0] fetch_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  state;
    logic [11:0] pc;
    logic [2:0]  lat_cnt;
    logic        flush;
    logic [11:0] next_pc;
    logic        redirect;

    // flush doubles as "pc already redirected" while holding, so no +1 is applied on ack.
    always_comb begin
        next_pc = pc + 12'd1;
        if (pc_load)
            next_pc = pc_load_addr;
        else if (flush)
            next_pc = pc;
    end

    // A redirect arriving on the last wait cycle must still discard the stale word.
    assign redirect = flush || pc_load;

    // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            lat_cnt     <= '0;
            flush       <= 1'b0;
            ifu_rd_req  <= 1'b0;
            ifu_rd_addr <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ifu_rd_req  <= 1'b0;
            ifu_rd_addr <= '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc          <= base_addr;
                        flush       <= 1'b0;
                        state       <= S_REQ;
                        busy        <= 1'b1;
                        ifu_rd_req  <= 1'b1;
                        ifu_rd_addr <= base_addr;
                    end else if (pc_load) begin
                        pc <= pc_load_addr;
                    end
                end
                S_REQ: begin
                    lat_cnt <= 3'(RD_LATENCY - 1);
                    state   <= S_WAIT;
                    if (pc_load) begin
                        pc    <= pc_load_addr;
                        flush <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        if (redirect) begin
                            flush       <= 1'b0;
                            state       <= S_REQ;
                            ifu_rd_req  <= 1'b1;
                            ifu_rd_addr <= pc_load ? pc_load_addr : pc;
                            pc          <= pc_load ? pc_load_addr : pc;
                        end else begin
                            instr       <= ifu_rd_data;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state       <= S_HOLD;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                        if (pc_load) begin
                            pc    <= pc_load_addr;
                            flush <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (instr_ack) begin
                        instr_valid <= 1'b0;
                        pc          <= next_pc;
                        flush       <= 1'b0;
                        if (halt) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state       <= S_REQ;
                            ifu_rd_req  <= 1'b1;
                            ifu_rd_addr <= next_pc;
                        end
                    end else if (pc_load) begin
                        pc    <= pc_load_addr;
                        flush <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFU_FETCH_STATS_EN
    logic accept;
    assign accept = (state == S_HOLD) && instr_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetch_count <= '0;
        else if (accept)
            fetch_count <= fetch_count + 16'd1;
    end
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_pdp8_ifu_fetch_initiator.sv
// Directed bench for pdp8_ifu_fetch_initiator with a fixed-latency memory responder.
module tb_pdp8_ifu_fetch_initiator;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic        halt = 1'b0;
    logic        ifu_rd_req;
    logic [11:0] ifu_rd_addr;
    logic [11:0] ifu_rd_data = 12'o5252;
    logic [11:0] instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        instr_ack = 1'b0;
    logic        pc_load = 1'b0;
    logic [11:0] pc_load_addr = '0;
    logic        busy;
    logic [15:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_count = 0;

    pdp8_ifu_fetch_initiator #(.RD_LATENCY(RD_LAT), .RESET_PC(12'o0200)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .halt(halt),
        .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ack(instr_ack),
        .pc_load(pc_load), .pc_load_addr(pc_load_addr), .busy(busy), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Memory contents: word at addr is addr + 12'o6600 (so 12'o0200 holds 12'o7000).
    function automatic logic [11:0] mem_word(input logic [11:0] a);
        return a + 12'o6600;
    endfunction

    // Responder: a request seen in cycle t is answered with data driven through cycle t+RD_LAT.
    logic        pv [0:RD_LAT];
    logic [11:0] pa [0:RD_LAT];
    always @(negedge clk) begin
        for (int i = RD_LAT; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = ifu_rd_req;
        pa[0] = ifu_rd_addr;
        ifu_rd_data = pv[RD_LAT] ? mem_word(pa[RD_LAT]) : 12'o5252;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [11:0] a);
        base_addr = a;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits for the next request; no instruction may be presented in the meantime.
    task automatic wait_req(input logic [11:0] exp_addr, input string tag);
        int  seen_valid = 0;
        bit  got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (instr_valid) seen_valid++;
            if (ifu_rd_req) got = 1;
        end
        check({tag, "_req_seen"}, 16'(got), 16'd1);
        if (got) check({tag, "_addr"}, 16'(ifu_rd_addr), 16'(exp_addr));
        check({tag, "_no_valid"}, 16'(seen_valid), 16'd0);
    endtask

    task automatic wait_valid(input logic [11:0] exp_pc, input string tag);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (instr_valid) got = 1;
        end
        check({tag, "_valid_seen"}, 16'(got), 16'd1);
        if (got) begin
            check({tag, "_instr"}, 16'(instr), 16'(mem_word(exp_pc)));
            check({tag, "_instr_pc"}, 16'(instr_pc), 16'(exp_pc));
        end
    endtask

    // Acknowledge the presented instruction across the next rising edge.
    task automatic accept();
        instr_ack = 1'b1;
        @(posedge clk);
        #1 instr_ack = 1'b0;
        exp_count++;
    endtask

    function automatic logic [15:0] exp_fc();
`ifdef IFU_FETCH_STATS_EN
        return 16'(exp_count);
`else
        return 16'd0;
`endif
    endfunction

    initial begin
        for (int i = 0; i <= RD_LAT; i++) begin
            pv[i] = 1'b0;
            pa[i] = '0;
        end
        #1;
        check("rst_req", 16'(ifu_rd_req), 16'd0);
        check("rst_addr", 16'(ifu_rd_addr), 16'd0);
        check("rst_valid", 16'(instr_valid), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_count", fetch_count, 16'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Cycle-exact first fetch: start in cycle 0, request cycle 1, valid cycle 4.
        do_start(12'o0200);
        @(negedge clk);
        check("c1_req", 16'(ifu_rd_req), 16'd1);
        check("c1_addr", 16'(ifu_rd_addr), 16'o0200);
        check("c1_busy", 16'(busy), 16'd1);
        @(negedge clk);
        check("c2_req", 16'(ifu_rd_req), 16'd0);
        check("c2_addr", 16'(ifu_rd_addr), 16'd0);
        check("c2_valid", 16'(instr_valid), 16'd0);
        @(negedge clk);
        check("c3_valid", 16'(instr_valid), 16'd0);
        @(negedge clk);
        check("c4_valid", 16'(instr_valid), 16'd1);
        check("c4_instr", 16'(instr), 16'o7000);
        check("c4_pc", 16'(instr_pc), 16'o0200);
        accept();
        @(negedge clk);
        check("c5_req", 16'(ifu_rd_req), 16'd1);
        check("c5_addr", 16'(ifu_rd_addr), 16'o0201);
        check("c5_valid", 16'(instr_valid), 16'd0);

        // Decode stalls for five cycles: word stays put, nothing new is requested.
        wait_valid(12'o0201, "stall");
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 16'(instr_valid), 16'd1);
            check("stall_instr", 16'(instr), 16'(mem_word(12'o0201)));
            check("stall_pc", 16'(instr_pc), 16'o0201);
            check("stall_noreq", 16'(ifu_rd_req), 16'd0);
            if (i < 4) @(negedge clk);
        end
        accept();
        wait_req(12'o0202, "after_stall");

        // Halt alone does nothing; halt with ack returns to idle.
        wait_valid(12'o0202, "halt");
        halt = 1'b1;
        @(negedge clk);
        check("halt_noack_valid", 16'(instr_valid), 16'd1);
        check("halt_noack_busy", 16'(busy), 16'd1);
        accept();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("halted_busy", 16'(busy), 16'd0);
            check("halted_req", 16'(ifu_rd_req), 16'd0);
            check("halted_valid", 16'(instr_valid), 16'd0);
        end
        halt = 1'b0;
        do_start(12'o1000);
        wait_req(12'o1000, "resume");
        wait_valid(12'o1000, "resume");
        halt = 1'b1;
        accept();
        halt = 1'b0;

        // PC wrap from 12'o7777 to 12'o0000.
        do_start(12'o7777);
        wait_req(12'o7777, "wrap_first");
        wait_valid(12'o7777, "wrap_first");
        accept();
        wait_req(12'o0000, "wrap");
        wait_valid(12'o0000, "wrap");
        halt = 1'b1;
        accept();
        halt = 1'b0;

        // Redirect during the wait: old word dropped, next request targets the new pc.
        do_start(12'o0300);
        wait_req(12'o0300, "flush_first");
        @(negedge clk);
        pc_load_addr = 12'o0400;
        pc_load = 1'b1;
        @(negedge clk);
        pc_load = 1'b0;
        check("flush_valid", 16'(instr_valid), 16'd0);
        wait_req(12'o0400, "flush");
        wait_valid(12'o0400, "flush");
        halt = 1'b1;
        accept();
        halt = 1'b0;
        @(negedge clk);
        check("count_before_reset", fetch_count, exp_fc());

        // Reset in the middle of a fetch; the responder still drives late data.
        do_start(12'o0500);
        wait_req(12'o0500, "rst_mid");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstmid_req", 16'(ifu_rd_req), 16'd0);
        check("rstmid_addr", 16'(ifu_rd_addr), 16'd0);
        check("rstmid_instr", 16'(instr), 16'd0);
        check("rstmid_pc", 16'(instr_pc), 16'd0);
        check("rstmid_valid", 16'(instr_valid), 16'd0);
        check("rstmid_busy", 16'(busy), 16'd0);
        check("rstmid_count", fetch_count, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_valid", 16'(instr_valid), 16'd0);
            check("post_rst_req", 16'(ifu_rd_req), 16'd0);
            check("post_rst_busy", 16'(busy), 16'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
